// File: rtl/sccpu_datamem.sv
// Data-side memory for the single-cycle CPU: word RAM plus an MMIO block
// holding a free-running timer with compare/irq and a byte-wide TX FIFO.
module sccpu_datamem #(
  parameter int AW  = 6,
  parameter int TXD = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        wmem,
  output logic [31:0] mem,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        irq
);

  localparam int PW = $clog2(TXD);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(TXD);

  logic [31:0]   ram [0:(2**AW)-1];
  logic [7:0]    fifo_mem [0:TXD-1];
  logic [31:0]   timer;
  logic [31:0]   tcmp;
  logic          match;
  logic          overflow;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   status;

  logic          sel_mmio;
  logic [1:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          st_timer, st_tcmp, st_status, st_txdata;
  logic          full, empty, push, pop;
  logic          unused_addr_bits;

  assign sel_mmio = addr[31];
  assign reg_sel  = addr[3:2];
  assign ram_idx  = addr[AW+1:2];
  assign unused_addr_bits = ^{addr[30:AW+2], addr[1:0]};

  assign st_timer  = wmem & sel_mmio & (reg_sel == 2'd0);
  assign st_tcmp   = wmem & sel_mmio & (reg_sel == 2'd1);
  assign st_status = wmem & sel_mmio & (reg_sel == 2'd2);
  assign st_txdata = wmem & sel_mmio & (reg_sel == 2'd3);

  assign full     = (count == FULL_COUNT);
  assign empty    = (count == '0);
  assign push     = st_txdata & ~full;
  assign pop      = ~empty & tx_ready;
  assign tx_valid = ~empty;
  assign tx_data  = fifo_mem[rd_ptr];
  assign irq      = match;

  // RAM has no reset; stores are suppressed while reset is held
  always_ff @(posedge clock) begin
    if (!reset && wmem && !sel_mmio)
      ram[ram_idx] <= data;
  end

  always_ff @(posedge clock) begin
    if (push)
      fifo_mem[wr_ptr] <= data[7:0];
  end

  // Set terms are ORed in after the clear so a same-cycle set always wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timer    <= '0;
      tcmp     <= 32'hFFFF_FFFF;
      match    <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      timer <= st_timer ? data : timer + 32'd1;
      if (st_tcmp)
        tcmp <= data;
      match    <= (timer == tcmp) | (match & ~(st_status & data[2]));
      overflow <= (st_txdata & full) | (overflow & ~(st_status & data[3]));
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    status        = '0;
    status[0]     = full;
    status[1]     = empty;
    status[2]     = match;
    status[3]     = overflow;
    status[4 +: CW] = count;
  end

  always_comb begin
    mem = '0;
    if (!sel_mmio) begin
      mem = ram[ram_idx];
    end else begin
      case (reg_sel)
        2'd0:    mem = timer;
        2'd1:    mem = tcmp;
        2'd2:    mem = status;
        default: mem = '0;
      endcase
    end
  end

endmodule
